// File: rtl/alu_cmd_dispatcher.sv
// alu_cmd_dispatcher: buffers ALU commands in a small circular FIFO, drops
// illegal opcodes, and issues one command at a time to the memory-operand
// ALU. After every start it enforces a fixed number of idle cycles.
//
// Handshakes:
//   upstream: a command transfers on a cycle where cmd_valid && cmd_ready.
//             cmd_ready depends on registered state only, so it never
//             depends on cmd_valid.
//   ALU:      alu_start is a single-cycle pulse. It rises only while
//             alu_ready is high. alu_opcode and alu_addr are meaningful
//             while alu_start is high.
module alu_cmd_dispatcher #(
  parameter int DEPTH  = 4,
  parameter int OP_W   = 8,
  parameter int ADDR_W = 20,
  parameter int GAP    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OP_W-1:0]          cmd_opcode,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic                     alu_ready,
  output logic                     alu_start,
  output logic [OP_W-1:0]          alu_opcode,
  output logic [ADDR_W-1:0]        alu_addr,
  output logic                     err_opcode,
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [OP_W-1:0]  OP_ADD   = OP_W'(8'h05);
  localparam logic [OP_W-1:0]  OP_MUL   = OP_W'(8'h06);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [2:0]       GAP_LOAD = 3'(GAP);

  // Dispatch state. ST_IDLE may issue. ST_GAP counts out the idle cycles
  // required after a start. Any other encoding falls back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GAP  = 2'b01
  } state_t;

  state_t            state;
  logic [2:0]        gap_cnt;

  logic [OP_W-1:0]   op_mem   [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic [OP_W-1:0]   hold_opcode;
  logic [ADDR_W-1:0] hold_addr;

  logic              opcode_legal;
  logic              xfer;
  logic              push;
  logic              drop;
  logic              pop;
  logic              fifo_nonempty;

  assign fifo_nonempty = (fifo_level != '0);
  assign cmd_ready     = (fifo_level != FULL_LVL);
  assign opcode_legal  = (cmd_opcode == OP_ADD) || (cmd_opcode == OP_MUL);
  assign xfer          = cmd_valid && cmd_ready;
  assign push          = xfer && opcode_legal;
  assign drop          = xfer && !opcode_legal;

  // Start is combinational so a queued command issues in the same cycle
  // alu_ready rises. It is masked during reset so nothing is issued then.
  assign alu_start = !rst && (state == ST_IDLE) && fifo_nonempty && alu_ready;
  assign pop       = alu_start;

  // Show the FIFO head while there is one. Otherwise repeat the last head.
  assign alu_opcode = fifo_nonempty ? op_mem[rd_ptr]   : hold_opcode;
  assign alu_addr   = fifo_nonempty ? addr_mem[rd_ptr] : hold_addr;

  assign busy = fifo_nonempty || (state != ST_IDLE);

  // FIFO storage. The array is not reset because only valid slots are read.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= cmd_opcode;
      addr_mem[wr_ptr] <= cmd_addr;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Capture the head each cycle so the ALU outputs stay stable once the FIFO drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_opcode <= '0;
      hold_addr   <= '0;
    end else if (fifo_nonempty) begin
      hold_opcode <= op_mem[rd_ptr];
      hold_addr   <= addr_mem[rd_ptr];
    end
  end

  // Illegal-opcode reporting: one-cycle pulse and a saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_opcode <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      err_opcode <= drop;
      if (drop && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'h01;
      end
    end
  end

  // Dispatch FSM. Each start is followed by GAP cycles in ST_GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      gap_cnt <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (alu_start) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (gap_cnt <= 3'd1) begin
            state   <= ST_IDLE;
            gap_cnt <= 3'd0;
          end else begin
            gap_cnt <= gap_cnt - 3'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          gap_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Interface rules the ALU depends on.
  a_start_needs_ready : assert property (@(posedge clk) disable iff (rst)
    alu_start |-> alu_ready);
  a_start_legal_op    : assert property (@(posedge clk) disable iff (rst)
    alu_start |-> ((alu_opcode == OP_ADD) || (alu_opcode == OP_MUL)));
  a_no_start_in_gap   : assert property (@(posedge clk) disable iff (rst)
    (state == ST_GAP) |-> !alu_start);

endmodule
